// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/LS request-response channels and the unified RAM port
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  modport slave (
    input  if_req_valid, if_addr, ls_req_valid, ls_addr, ls_we, ls_funct3, ls_wdata, ram_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, if_err, ls_req_ready, ls_rsp_valid, ls_rdata, ls_err,
           ram_addr, ram_sel, ram_we, ram_wdata
  );
  modport master (
    output if_req_valid, if_addr, ls_req_valid, ls_addr, ls_we, ls_funct3, ls_wdata, ram_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, if_err, ls_req_ready, ls_rsp_valid, ls_rdata, ls_err,
           ram_addr, ram_sel, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one RAM port between fetch and load/store,
// with byte-lane select, write replication, load extension and alignment checks.
module mem_port_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_ls_q, owner_ls_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic [3:0]  sel_q;
  logic        win_ls, accept, last_cyc, n_err;
  logic [1:0]  sz;
  logic [31:0] n_addr, n_wdata, ext;
  logic [3:0]  n_sel;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign win_ls   = bus.ls_req_valid & (~bus.if_req_valid | ~last_ls_q);
  assign accept   = (state_q == IDLE) & (bus.if_req_valid | bus.ls_req_valid);
  assign last_cyc = cnt_q == CW'(WAIT_CYC - 1);
  assign n_addr   = win_ls ? bus.ls_addr : bus.if_addr;
  assign sz       = win_ls ? bus.ls_funct3[1:0] : 2'b10;
  assign n_sel    = sz == 2'b00 ? 4'b0001 << n_addr[1:0] :
                    sz == 2'b01 ? (n_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign n_err    = (sz == 2'b11) | (sz == 2'b01 & n_addr[0]) | (sz == 2'b10 & |n_addr[1:0]);
  assign n_wdata  = sz == 2'b00 ? {4{bus.ls_wdata[7:0]}} :
                    sz == 2'b01 ? {2{bus.ls_wdata[15:0]}} : bus.ls_wdata;
  assign lane_b   = bus.ram_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h   = addr_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
  // IF transactions latch funct3=010 so they fall through to the raw word
  assign ext      = we_q ? 32'h0 :
                    f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane_b[7]}}, lane_b} :
                    f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} : bus.ram_rdata;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    state_d = accept ? (n_err ? RESP : ACCESS) : IDLE;
      ACCESS: begin
        cnt_d   = last_cyc ? '0 : cnt_q + 1'b1;
        state_d = last_cyc ? RESP : ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ls_q  <= 1'b1;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      f3_q       <= '0;
      sel_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_ls_q  <= win_ls;
        owner_ls_q <= win_ls;
        we_q       <= win_ls & bus.ls_we;
        err_q      <= n_err;
        addr_q     <= n_addr;
        wdata_q    <= n_wdata;
        rdata_q    <= '0;
        f3_q       <= win_ls ? bus.ls_funct3 : 3'b010;
        sel_q      <= n_sel;
      end
      if (state_q == ACCESS && last_cyc) rdata_q <= ext;
    end
  end
  assign bus.if_req_ready = accept & ~win_ls;
  assign bus.ls_req_ready = accept & win_ls;
  assign bus.if_rsp_valid = (state_q == RESP) & ~owner_ls_q;
  assign bus.ls_rsp_valid = (state_q == RESP) & owner_ls_q;
  assign bus.if_rdata     = bus.if_rsp_valid ? rdata_q : '0;
  assign bus.ls_rdata     = bus.ls_rsp_valid ? rdata_q : '0;
  assign bus.if_err       = bus.if_rsp_valid & err_q;
  assign bus.ls_err       = bus.ls_rsp_valid & err_q;
  assign bus.ram_addr     = {addr_q[31:2], 2'b00};
  assign bus.ram_sel      = state_q == ACCESS ? sel_q : 4'b0000;
  assign bus.ram_we       = (state_q == ACCESS) & we_q;
  assign bus.ram_wdata    = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus round-robin and reset-abort sequences
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_mode = 1'b0;
  logic [31:0] ram_val = '0;
  localparam logic [31:0] K = 32'hA5A5_0000;
  int n_vec = 0;
  int n_bad = 0;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.WAIT_CYC(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.ram_rdata = ram_mode ? (bus.ram_addr ^ K) : ram_val;
  always #5 clk = ~clk;
  typedef struct {
    bit          ls;
    logic [31:0] addr;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  sel;
    bit          xwe;
    logic [31:0] xwd;
    bit          err;
    logic [31:0] xrd;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int lat;
    logic got;
    @(negedge clk);
    ram_mode = 1'b0;
    ram_val  = v.rd;
    if (v.ls) begin
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = v.addr;
      bus.ls_we        = v.we;
      bus.ls_funct3    = v.f3;
      bus.ls_wdata     = v.wd;
    end else begin
      bus.if_req_valid = 1'b1;
      bus.if_addr      = v.addr;
    end
    #1 chk("req_ready", v.ls ? bus.ls_req_ready : bus.if_req_ready, 1);
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    bus.if_req_valid = 1'b0;
    chk("ram_sel", bus.ram_sel, v.sel);
    chk("ram_we", bus.ram_we, v.xwe);
    if (!v.err) begin
      chk("ram_addr", bus.ram_addr, {v.addr[31:2], 2'b00});
      if (v.xwe) chk("ram_wdata", bus.ram_wdata, v.xwd);
    end
    lat = 1;
    got = v.ls ? bus.ls_rsp_valid : bus.if_rsp_valid;
    while (!got && lat < 6) begin
      @(negedge clk);
      lat++;
      got = v.ls ? bus.ls_rsp_valid : bus.if_rsp_valid;
    end
    chk("rsp_latency", lat, v.err ? 1 : 2);
    chk("rsp_rdata", v.ls ? bus.ls_rdata : bus.if_rdata, v.xrd);
    chk("rsp_err", v.ls ? bus.ls_err : bus.if_err, v.err);
    @(negedge clk);
    chk("rsp_oneshot", bus.ls_rsp_valid | bus.if_rsp_valid, 0);
  endtask
  initial begin
    int nr;
    logic got;
    vt[0]  = '{0, 32'h10, 0, 3'b010, 32'h0,        32'hDEADBEEF, 4'b1111, 0, 32'h0,        0, 32'hDEADBEEF};
    vt[1]  = '{1, 32'h13, 1, 3'b000, 32'h000000AB, 32'h0,        4'b1000, 1, 32'hABABABAB, 0, 32'h0};
    vt[2]  = '{1, 32'h22, 0, 3'b001, 32'h0,        32'h80011234, 4'b1100, 0, 32'h0,        0, 32'hFFFF8001};
    vt[3]  = '{1, 32'h22, 0, 3'b101, 32'h0,        32'h80011234, 4'b1100, 0, 32'h0,        0, 32'h00008001};
    vt[4]  = '{1, 32'h20, 0, 3'b000, 32'h0,        32'h80011234, 4'b0001, 0, 32'h0,        0, 32'h00000034};
    vt[5]  = '{1, 32'h06, 0, 3'b010, 32'h0,        32'h12345678, 4'b0000, 0, 32'h0,        1, 32'h0};
    vt[6]  = '{1, 32'h40, 0, 3'b011, 32'h0,        32'h12345678, 4'b0000, 0, 32'h0,        1, 32'h0};
    vt[7]  = '{0, 32'h12, 0, 3'b010, 32'h0,        32'h12345678, 4'b0000, 0, 32'h0,        1, 32'h0};
    vt[8]  = '{1, 32'h16, 1, 3'b001, 32'h1234ABCD, 32'h0,        4'b1100, 1, 32'hABCDABCD, 0, 32'h0};
    vt[9]  = '{1, 32'h18, 1, 3'b010, 32'h12345678, 32'h0,        4'b1111, 1, 32'h12345678, 0, 32'h0};
    vt[10] = '{1, 32'h21, 0, 3'b000, 32'h0,        32'h000080FF, 4'b0010, 0, 32'h0,        0, 32'hFFFFFF80};
    vt[11] = '{1, 32'h21, 0, 3'b100, 32'h0,        32'h000080FF, 4'b0010, 0, 32'h0,        0, 32'h00000080};
    bus.if_req_valid = 0; bus.if_addr = 0;
    bus.ls_req_valid = 0; bus.ls_addr = 0; bus.ls_we = 0; bus.ls_funct3 = 0; bus.ls_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ram_sel", bus.ram_sel, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_rsp", {bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_req_ready, bus.ls_req_ready}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run(vt[i]);
    // both requesters held valid from reset: strict alternation starting with IF
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ram_mode = 1'b1;
    bus.if_addr = 32'h100; bus.if_req_valid = 1'b1;
    bus.ls_addr = 32'h200; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b010; bus.ls_req_valid = 1'b1;
    nr = 0;
    for (int c = 0; c < 30 && nr < 4; c++) begin
      #1;
      if (bus.if_rsp_valid) begin
        chk("rr_if_turn", nr % 2, 0);
        chk("rr_if_rdata", bus.if_rdata, 32'h100 ^ K);
        nr++;
      end else if (bus.ls_rsp_valid) begin
        chk("rr_ls_turn", nr % 2, 1);
        chk("rr_ls_rdata", bus.ls_rdata, 32'h200 ^ K);
        nr++;
      end
      @(negedge clk);
    end
    chk("rr_count", nr, 4);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    ram_mode = 1'b0;
    // reset asserted while a store is on the RAM port
    bus.ls_req_valid = 1'b1; bus.ls_addr = 32'h30; bus.ls_we = 1'b1;
    bus.ls_funct3 = 3'b010; bus.ls_wdata = 32'h11223344;
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    chk("abort_pre_we", bus.ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", bus.ram_we, 0);
    chk("abort_sel", bus.ram_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      got = got | bus.ls_rsp_valid | bus.if_rsp_valid | bus.ram_we;
    end
    chk("abort_no_rsp", got, 0);
    run(vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
